// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - data-memory req/ack bus between the MEM stage and data memory
interface mem_access_stage_if;
  logic        DMem_Req;
  logic        DMem_We;
  logic [31:0] DMem_Addr;
  logic [3:0]  DMem_Be;
  logic [31:0] DMem_Wdata;
  logic        DMem_Ack;
  logic [31:0] DMem_Rdata;

  modport master (
    output DMem_Req,
    output DMem_We,
    output DMem_Addr,
    output DMem_Be,
    output DMem_Wdata,
    input  DMem_Ack,
    input  DMem_Rdata
  );

  modport slave (
    input  DMem_Req,
    input  DMem_We,
    input  DMem_Addr,
    input  DMem_Be,
    input  DMem_Wdata,
    output DMem_Ack,
    output DMem_Rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM-stage data-memory access unit with load alignment, stall and timeout watchdog
module mem_access_stage #(
  parameter bit          BIG_ENDIAN     = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               MemRead_MEM,
  input  logic               MemWrite_MEM,
  input  logic [1:0]         MemSize_MEM,
  input  logic               MemSigned_MEM,
  input  logic [31:0]        ALU_Result_MEM,
  input  logic [31:0]        Write_Data_MEM,
  mem_access_stage_if.master dmem,
  output logic [31:0]        Read_Data_MEM,
  output logic               Stall_MEM,
  output logic               Misaligned_MEM,
  output logic               Bus_Error_MEM
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // The counter holds the number of completed ACCESS cycles without ack,
  // so the last allowed cycle is the one where it equals TIMEOUT_CYCLES-1.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      state_next;

  logic        access;
  logic        is_byte;
  logic        is_half;
  logic        misaligned;
  logic        start;
  logic [1:0]  byte_lane;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;

  logic        load_q;
  logic        is_byte_q;
  logic        is_half_q;
  logic        signed_q;
  logic [1:0]  byte_lane_q;
  logic [15:0] wait_cnt_q;
  logic        timeout_hit;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // Request decode from the EX/MEM fields
  assign access     = MemRead_MEM | MemWrite_MEM;
  assign is_byte    = (MemSize_MEM == 2'b00);
  assign is_half    = (MemSize_MEM == 2'b01);
  assign misaligned = is_half ? ALU_Result_MEM[0]
                              : (!is_byte && (ALU_Result_MEM[1:0] != 2'b00));
  assign start      = (state == IDLE) && access && !misaligned;

  // Physical lane of the addressed byte; bit 1 also selects the half-lane.
  assign byte_lane  = BIG_ENDIAN ? ~ALU_Result_MEM[1:0] : ALU_Result_MEM[1:0];

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = Write_Data_MEM;
    if (is_byte) begin
      be_next    = 4'b0001 << byte_lane;
      wdata_next = {4{Write_Data_MEM[7:0]}};
    end else if (is_half) begin
      be_next    = byte_lane[1] ? 4'b1100 : 4'b0011;
      wdata_next = {2{Write_Data_MEM[15:0]}};
    end
  end

  assign timeout_hit = (wait_cnt_q == TIMEOUT_LAST);

  // Load extraction from the word returned with the ack
  always_comb begin
    ld_byte = dmem.DMem_Rdata[7:0];
    case (byte_lane_q)
      2'd0:    ld_byte = dmem.DMem_Rdata[7:0];
      2'd1:    ld_byte = dmem.DMem_Rdata[15:8];
      2'd2:    ld_byte = dmem.DMem_Rdata[23:16];
      default: ld_byte = dmem.DMem_Rdata[31:24];
    endcase
  end

  assign ld_half = byte_lane_q[1] ? dmem.DMem_Rdata[31:16] : dmem.DMem_Rdata[15:0];

  always_comb begin
    ld_data = dmem.DMem_Rdata;
    if (is_byte_q) begin
      ld_data = {{24{signed_q & ld_byte[7]}}, ld_byte};
    end else if (is_half_q) begin
      ld_data = {{16{signed_q & ld_half[15]}}, ld_half};
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // DONE releases the stall for exactly one cycle so the pipeline advances
  // before the next instruction is examined in IDLE.
  always_comb begin
    state_next     = state;
    Stall_MEM      = 1'b0;
    Misaligned_MEM = 1'b0;
    case (state)
      IDLE: begin
        Misaligned_MEM = access & misaligned;
        if (start) begin
          Stall_MEM  = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        Stall_MEM = 1'b1;
        if (dmem.DMem_Ack || timeout_hit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      dmem.DMem_Req   <= 1'b0;
      dmem.DMem_We    <= 1'b0;
      dmem.DMem_Addr  <= 32'h0;
      dmem.DMem_Be    <= 4'h0;
      dmem.DMem_Wdata <= 32'h0;
      Read_Data_MEM   <= 32'h0;
      Bus_Error_MEM   <= 1'b0;
      load_q          <= 1'b0;
      is_byte_q       <= 1'b0;
      is_half_q       <= 1'b0;
      signed_q        <= 1'b0;
      byte_lane_q     <= 2'd0;
      wait_cnt_q      <= 16'h0;
    end else begin
      Bus_Error_MEM <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dmem.DMem_Req   <= 1'b1;
            dmem.DMem_We    <= MemWrite_MEM;
            dmem.DMem_Addr  <= {ALU_Result_MEM[31:2], 2'b00};
            dmem.DMem_Be    <= be_next;
            dmem.DMem_Wdata <= wdata_next;
            load_q          <= MemRead_MEM & ~MemWrite_MEM;
            is_byte_q       <= is_byte;
            is_half_q       <= is_half;
            signed_q        <= MemSigned_MEM;
            byte_lane_q     <= byte_lane;
            wait_cnt_q      <= 16'h0;
          end
        end
        ACCESS: begin
          // An ack on the final allowed cycle still completes normally.
          if (dmem.DMem_Ack) begin
            dmem.DMem_Req <= 1'b0;
            if (load_q) begin
              Read_Data_MEM <= ld_data;
            end
          end else if (timeout_hit) begin
            dmem.DMem_Req <= 1'b0;
            Read_Data_MEM <= 32'h0;
            Bus_Error_MEM <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 16'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
